// File: rtl/fpu_dp_result_stage.sv
// Result stage for the double-precision FPU: a 2-entry skid FIFO carrying each result word with
// its overflow/underflow flags, zero/inf decode of the head entry, and sticky exception flags.
module fpu_dp_result_stage #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_overflow,
  input  logic             in_underflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_overflow,
  output logic             out_underflow,
  output logic             out_zero,
  output logic             out_inf,
  input  logic             flag_clr,
  output logic             sticky_overflow,
  output logic             sticky_underflow,
  output logic [1:0]       count
);

  localparam int unsigned ManW = WIDTH - 12;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             ovf;
    logic             unf;
  } entry_t;

  entry_t     mem_q [2];
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] count_q, count_d;
  logic       sticky_ovf_q, sticky_ovf_d;
  logic       sticky_unf_q, sticky_unf_d;
  logic       push, pop;
  entry_t     head;
  logic [10:0]     head_exp;
  logic [ManW-1:0] head_man;

  // Handshake depends only on registered count, so in_ready never sees out_ready.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (!push && pop) begin
      count_d = count_q - 2'd1;
    end
  end

  // Set wins over clear when both happen in the same cycle.
  assign sticky_ovf_d = (push & in_overflow) | (sticky_ovf_q & ~flag_clr);
  assign sticky_unf_d = (push & in_underflow) | (sticky_unf_q & ~flag_clr);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      sticky_ovf_q <= 1'b0;
      sticky_unf_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_q ^ push;
      rd_ptr_q     <= rd_ptr_q ^ pop;
      count_q      <= count_d;
      sticky_ovf_q <= sticky_ovf_d;
      sticky_unf_q <= sticky_unf_d;
    end
  end

  // Storage needs no reset: every output is masked by out_valid.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= '{result: in_result, ovf: in_overflow, unf: in_underflow};
    end
  end

  always_comb begin
    head = '0;
    if (out_valid) begin
      head = mem_q[rd_ptr_q];
    end
  end

  assign head_exp = head.result[WIDTH-2 -: 11];
  assign head_man = head.result[ManW-1:0];

  assign out_result       = head.result;
  assign out_overflow     = head.ovf;
  assign out_underflow    = head.unf;
  assign out_zero         = out_valid & (head_exp == 11'h000) & (head_man == '0);
  assign out_inf          = out_valid & (head_exp == 11'h7FF) & (head_man == '0);
  assign sticky_overflow  = sticky_ovf_q;
  assign sticky_underflow = sticky_unf_q;
  assign count            = count_q;

endmodule

// File: tb/tb_fpu_dp_result_stage.sv
// Bench for fpu_dp_result_stage: directed vector table, then random traffic against a queue model.
module tb_fpu_dp_result_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_overflow, in_underflow;
  logic [63:0] in_result, out_result;
  logic        out_valid, out_ready, out_overflow, out_underflow, out_zero, out_inf;
  logic        flag_clr, sticky_overflow, sticky_underflow;
  logic [1:0]  count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fpu_dp_result_stage #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_overflow(in_overflow), .in_underflow(in_underflow), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_overflow(out_overflow),
    .out_underflow(out_underflow), .out_zero(out_zero), .out_inf(out_inf),
    .flag_clr(flag_clr), .sticky_overflow(sticky_overflow),
    .sticky_underflow(sticky_underflow), .count(count)
  );

  typedef struct {
    logic rst, vld; logic [63:0] res; logic ov, un, rdy, clr;
    logic [1:0] e_cnt; logic e_irdy, e_ovld; logic [63:0] e_res;
    logic e_ov, e_un, e_zero, e_inf, e_sov, e_sun;
  } vec_t;

  typedef struct { logic [63:0] res; logic ov; logic un; } ent_t;

  function automatic vec_t mk(logic r, logic v, logic [63:0] d, logic ov, logic un, logic rdy,
                              logic clr, logic [1:0] c, logic ir, logic ovl, logic [63:0] er,
                              logic eov, logic eun, logic ez, logic ei, logic sov, logic sun);
    vec_t t;
    t.rst = r; t.vld = v; t.res = d; t.ov = ov; t.un = un; t.rdy = rdy; t.clr = clr;
    t.e_cnt = c; t.e_irdy = ir; t.e_ovld = ovl; t.e_res = er; t.e_ov = eov; t.e_un = eun;
    t.e_zero = ez; t.e_inf = ei; t.e_sov = sov; t.e_sun = sun;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] c, input logic ir, input logic ovl,
                           input logic [63:0] r, input logic ov, input logic un, input logic z,
                           input logic inf, input logic sov, input logic sun);
    chk({tag, ".count"}, 64'(count), 64'(c));
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(ir));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(ovl));
    chk({tag, ".out_result"}, out_result, r);
    chk({tag, ".out_overflow"}, 64'(out_overflow), 64'(ov));
    chk({tag, ".out_underflow"}, 64'(out_underflow), 64'(un));
    chk({tag, ".out_zero"}, 64'(out_zero), 64'(z));
    chk({tag, ".out_inf"}, 64'(out_inf), 64'(inf));
    chk({tag, ".sticky_ovf"}, 64'(sticky_overflow), 64'(sov));
    chk({tag, ".sticky_unf"}, 64'(sticky_underflow), 64'(sun));
  endtask

  // Reference model: a plain queue of entries plus two sticky bits.
  ent_t q[$];
  logic m_sov = 1'b0;
  logic m_sun = 1'b0;

  task automatic model_edge();
    bit do_push, do_pop;
    ent_t e;
    if (rst) begin
      q.delete();
      m_sov = 1'b0;
      m_sun = 1'b0;
    end else begin
      do_push = in_valid && (q.size() < 2);
      do_pop  = out_ready && (q.size() > 0);
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        e.res = in_result; e.ov = in_overflow; e.un = in_underflow;
        q.push_back(e);
      end
      m_sov = (do_push && in_overflow) ? 1'b1 : (flag_clr ? 1'b0 : m_sov);
      m_sun = (do_push && in_underflow) ? 1'b1 : (flag_clr ? 1'b0 : m_sun);
    end
  endtask

  function automatic logic [63:0] rand_word();
    logic [63:0] w;
    logic s;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 4))
      0: w = {s, 11'h000, 52'h0};
      1: w = {s, 11'h7FF, 52'h0};
      2: w = {s, 11'h7FF, 52'h1 << $urandom_range(0, 51)};
      3: w = {s, 11'h000, 52'h1 << $urandom_range(0, 51)};
      default: w = {$urandom, $urandom};
    endcase
    return w;
  endfunction

  vec_t tbl[16];

  initial begin
    tbl[0]  = mk(0, 1, 64'h3FF0000000000000, 0, 0, 1, 0,
                 2'd1, 1, 1, 64'h3FF0000000000000, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 64'h0, 0, 0, 1, 0, 2'd0, 1, 0, 64'h0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 64'hFFF0000000000000, 1, 0, 0, 0,
                 2'd1, 1, 1, 64'hFFF0000000000000, 1, 0, 0, 1, 1, 0);
    tbl[3]  = mk(0, 0, 64'h0, 0, 0, 0, 0,
                 2'd1, 1, 1, 64'hFFF0000000000000, 1, 0, 0, 1, 1, 0);
    tbl[4]  = mk(0, 0, 64'h0, 0, 0, 0, 1,
                 2'd1, 1, 1, 64'hFFF0000000000000, 1, 0, 0, 1, 0, 0);
    tbl[5]  = mk(0, 0, 64'h0, 0, 0, 1, 0, 2'd0, 1, 0, 64'h0, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(0, 1, 64'h0, 0, 0, 0, 0, 2'd1, 1, 1, 64'h0, 0, 0, 1, 0, 0, 0);
    tbl[7]  = mk(0, 1, 64'h8000000000000000, 0, 0, 0, 0, 2'd2, 0, 1, 64'h0, 0, 0, 1, 0, 0, 0);
    tbl[8]  = mk(0, 1, 64'h1234, 0, 0, 0, 0, 2'd2, 0, 1, 64'h0, 0, 0, 1, 0, 0, 0);
    // Pop while full: the blocked push must still be refused this cycle.
    tbl[9]  = mk(0, 1, 64'h1234, 0, 0, 1, 0,
                 2'd1, 1, 1, 64'h8000000000000000, 0, 0, 1, 0, 0, 0);
    tbl[10] = mk(0, 0, 64'h0, 0, 0, 1, 0, 2'd0, 1, 0, 64'h0, 0, 0, 0, 0, 0, 0);
    tbl[11] = mk(0, 1, 64'h1, 0, 1, 0, 1, 2'd1, 1, 1, 64'h1, 0, 1, 0, 0, 0, 1);
    tbl[12] = mk(0, 1, 64'h7FF0000000000000, 0, 0, 0, 0, 2'd2, 0, 1, 64'h1, 0, 1, 0, 0, 0, 1);
    tbl[13] = mk(1, 1, 64'h5555, 1, 1, 1, 1, 2'd0, 1, 0, 64'h0, 0, 0, 0, 0, 0, 0);
    tbl[14] = mk(0, 1, 64'h4000000000000000, 0, 0, 0, 0,
                 2'd1, 1, 1, 64'h4000000000000000, 0, 0, 0, 0, 0, 0);
    tbl[15] = mk(0, 0, 64'h0, 0, 0, 1, 0, 2'd0, 1, 0, 64'h0, 0, 0, 0, 0, 0, 0);

    rst = 1'b1; in_valid = 1'b1; in_result = 64'hDEAD; in_overflow = 1'b1; in_underflow = 1'b1;
    out_ready = 1'b0; flag_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 2'd0, 1, 0, 64'h0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      rst = tbl[i].rst; in_valid = tbl[i].vld; in_result = tbl[i].res;
      in_overflow = tbl[i].ov; in_underflow = tbl[i].un; out_ready = tbl[i].rdy;
      flag_clr = tbl[i].clr;
      @(posedge clk);
      #1;
      check_all($sformatf("row%0d", i), tbl[i].e_cnt, tbl[i].e_irdy, tbl[i].e_ovld,
                tbl[i].e_res, tbl[i].e_ov, tbl[i].e_un, tbl[i].e_zero, tbl[i].e_inf,
                tbl[i].e_sov, tbl[i].e_sun);
    end

    // Table ends empty with clear stickies, which is the model's starting state.
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flag_clr = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      rst          = ($urandom_range(0, 99) == 0);
      in_valid     = 1'($urandom_range(0, 1));
      in_result    = rand_word();
      in_overflow  = ($urandom_range(0, 5) == 0);
      in_underflow = ($urandom_range(0, 5) == 0);
      out_ready    = ($urandom_range(0, 2) != 0);
      flag_clr     = ($urandom_range(0, 9) == 0);
      @(posedge clk);
      #1;
      model_edge();
      if (q.size() == 0) begin
        check_all("rand", 2'd0, 1, 0, 64'h0, 0, 0, 0, 0, m_sov, m_sun);
      end else begin
        check_all("rand", 2'(q.size()), q.size() < 2, 1, q[0].res, q[0].ov, q[0].un,
                  (q[0].res[62:52] == 11'h000) && (q[0].res[51:0] == 52'h0),
                  (q[0].res[62:52] == 11'h7FF) && (q[0].res[51:0] == 52'h0), m_sov, m_sun);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
